// File: rtl/speicher_schnittstelle_if.sv
// speicher_schnittstelle_if: single-port memory bus with ready handshake
interface speicher_schnittstelle_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWData;
    logic                  MemRead;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] MemRData;
    logic                  MemReady;

    modport master (
        output MemAddr, MemWData, MemRead, MemWrite,
        input  MemRData, MemReady
    );

    modport slave (
        input  MemAddr, MemWData, MemRead, MemWrite,
        output MemRData, MemReady
    );
endinterface

// File: rtl/speicher_schnittstelle.sv
// speicher_schnittstelle: serialises fetch, load and store onto one memory bus
module speicher_schnittstelle #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  LoadBefehlSignal,
    input  logic                  LoadDatenSignal,
    input  logic                  StoreDatenSignal,
    input  logic [ADDR_WIDTH-1:0] PC,
    input  logic [ADDR_WIDTH-1:0] DatenAdresse,
    input  logic [DATA_WIDTH-1:0] SchreibDaten,
    output logic [DATA_WIDTH-1:0] Befehl,
    output logic [DATA_WIDTH-1:0] GeladeneDaten,
    output logic                  BefehlGeladen,
    output logic                  DatenGeladen,
    output logic                  DatenGespeichert,
    output logic                  BusFehler,
    speicher_schnittstelle_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ZUGRIFF = 2'd1;
    localparam logic [1:0] FERTIG  = 2'd2;

    localparam logic [1:0] TYP_FETCH = 2'd0;
    localparam logic [1:0] TYP_LOAD  = 2'd1;
    localparam logic [1:0] TYP_STORE = 2'd2;

    logic [1:0]    state;
    logic [1:0]    accessType;
    logic [CW-1:0] waitCount;
    logic          originRequest;
    logic          timedOut;
    logic          finished;

    // level of the request that started the current access, and end-of-access detection
    always_comb begin
        originRequest = accessType == TYP_STORE ? StoreDatenSignal :
                        accessType == TYP_LOAD  ? LoadDatenSignal  : LoadBefehlSignal;
        timedOut      = !bus.MemReady && waitCount == CW'(TIMEOUT - 1);
        finished      = bus.MemReady || timedOut;
    end

    // access sequencer: issue, wait for ready or timeout, hold completion until request drops
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state            <= IDLE;
            accessType       <= TYP_FETCH;
            waitCount        <= '0;
            bus.MemAddr      <= '0;
            bus.MemWData     <= '0;
            bus.MemRead      <= 1'b0;
            bus.MemWrite     <= 1'b0;
            Befehl           <= '0;
            GeladeneDaten    <= '0;
            BefehlGeladen    <= 1'b0;
            DatenGeladen     <= 1'b0;
            DatenGespeichert <= 1'b0;
            BusFehler        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (StoreDatenSignal || LoadDatenSignal || LoadBefehlSignal) begin
                        accessType   <= StoreDatenSignal ? TYP_STORE :
                                        LoadDatenSignal  ? TYP_LOAD  : TYP_FETCH;
                        bus.MemAddr  <= (StoreDatenSignal || LoadDatenSignal) ? DatenAdresse : PC;
                        if (StoreDatenSignal)
                            bus.MemWData <= SchreibDaten;
                        bus.MemRead  <= !StoreDatenSignal;
                        bus.MemWrite <= StoreDatenSignal;
                        waitCount    <= '0;
                        state        <= ZUGRIFF;
                    end
                end
                ZUGRIFF: begin
                    if (finished) begin
                        bus.MemRead  <= 1'b0;
                        bus.MemWrite <= 1'b0;
                        if (accessType == TYP_FETCH)
                            Befehl <= bus.MemReady ? bus.MemRData : '0;
                        if (accessType == TYP_LOAD)
                            GeladeneDaten <= bus.MemReady ? bus.MemRData : '0;
                        if (timedOut)
                            BusFehler <= 1'b1;
                        BefehlGeladen    <= originRequest && accessType == TYP_FETCH;
                        DatenGeladen     <= originRequest && accessType == TYP_LOAD;
                        DatenGespeichert <= originRequest && accessType == TYP_STORE;
                        state            <= originRequest ? FERTIG : IDLE;
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
                end
                FERTIG: begin
                    if (!originRequest) begin
                        BefehlGeladen    <= 1'b0;
                        DatenGeladen     <= 1'b0;
                        DatenGespeichert <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_speicher_schnittstelle.sv
// tb_speicher_schnittstelle: directed checks of fetch, load, store, priority, timeout, async reset
module tb_speicher_schnittstelle;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        LoadBefehlSignal = 1'b0;
    logic        LoadDatenSignal = 1'b0;
    logic        StoreDatenSignal = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] DatenAdresse = '0;
    logic [31:0] SchreibDaten = '0;
    logic [31:0] Befehl;
    logic [31:0] GeladeneDaten;
    logic        BefehlGeladen;
    logic        DatenGeladen;
    logic        DatenGespeichert;
    logic        BusFehler;
    int          testCount = 0;
    int          failCount = 0;
    int          highCycles;

    speicher_schnittstelle_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    speicher_schnittstelle #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(15)) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .LoadBefehlSignal (LoadBefehlSignal),
        .LoadDatenSignal  (LoadDatenSignal),
        .StoreDatenSignal (StoreDatenSignal),
        .PC               (PC),
        .DatenAdresse     (DatenAdresse),
        .SchreibDaten     (SchreibDaten),
        .Befehl           (Befehl),
        .GeladeneDaten    (GeladeneDaten),
        .BefehlGeladen    (BefehlGeladen),
        .DatenGeladen     (DatenGeladen),
        .DatenGespeichert (DatenGespeichert),
        .BusFehler        (BusFehler),
        .bus              (bus.master)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // mutual exclusion of strobes and completions, checked every cycle out of reset
    always @(negedge Clock) begin
        if (!Reset) begin
            check("strobe_excl", 64'(bus.MemRead && bus.MemWrite), 64'd0);
            check("done_excl", 64'(($countones({BefehlGeladen, DatenGeladen, DatenGespeichert}) > 1)), 64'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemReady = 1'b0;
        bus.MemRData = '0;
        #3;
        check("rst_memread", 64'(bus.MemRead), 64'd0);
        check("rst_befehl", 64'(Befehl), 64'd0);
        check("rst_addr", 64'(bus.MemAddr), 64'd0);
        check("rst_fehler", 64'(BusFehler), 64'd0);
        #9 Reset = 1'b0;

        // fetch, zero-wait
        PC = 32'h10; bus.MemRData = 32'h8C220004; bus.MemReady = 1'b1; LoadBefehlSignal = 1'b1;
        tick();
        check("f_memread", 64'(bus.MemRead), 64'd1);
        check("f_addr", 64'(bus.MemAddr), 64'h10);
        check("f_done_early", 64'(BefehlGeladen), 64'd0);
        tick();
        check("f_memread_off", 64'(bus.MemRead), 64'd0);
        check("f_done", 64'(BefehlGeladen), 64'd1);
        check("f_befehl", 64'(Befehl), 64'h8C220004);
        tick();
        check("f_done_hold", 64'(BefehlGeladen), 64'd1);
        LoadBefehlSignal = 1'b0;
        tick();
        check("f_done_drop", 64'(BefehlGeladen), 64'd0);

        // load, 3 wait states
        bus.MemReady = 1'b0; DatenAdresse = 32'h200; LoadDatenSignal = 1'b1;
        highCycles = 0;
        repeat (4) begin
            tick();
            if (bus.MemRead) highCycles++;
        end
        check("l_addr", 64'(bus.MemAddr), 64'h200);
        check("l_done_wait", 64'(DatenGeladen), 64'd0);
        bus.MemReady = 1'b1; bus.MemRData = 32'hDEADBEEF;
        tick();
        bus.MemReady = 1'b0;
        check("l_memread_off", 64'(bus.MemRead), 64'd0);
        check("l_strobe_len", 64'(highCycles), 64'd4);
        check("l_daten", 64'(GeladeneDaten), 64'hDEADBEEF);
        check("l_done", 64'(DatenGeladen), 64'd1);
        check("l_fehler", 64'(BusFehler), 64'd0);
        check("l_befehl_kept", 64'(Befehl), 64'h8C220004);
        tick();
        check("l_done_hold", 64'(DatenGeladen), 64'd1);
        LoadDatenSignal = 1'b0;
        tick();
        check("l_done_drop", 64'(DatenGeladen), 64'd0);

        // store, 1 wait state
        DatenAdresse = 32'h300; SchreibDaten = 32'h12345678; StoreDatenSignal = 1'b1;
        tick();
        SchreibDaten = 32'hFFFF0000;
        check("s_memwrite", 64'(bus.MemWrite), 64'd1);
        check("s_memread", 64'(bus.MemRead), 64'd0);
        check("s_addr", 64'(bus.MemAddr), 64'h300);
        check("s_wdata", 64'(bus.MemWData), 64'h12345678);
        tick();
        check("s_memwrite2", 64'(bus.MemWrite), 64'd1);
        check("s_wdata2", 64'(bus.MemWData), 64'h12345678);
        bus.MemReady = 1'b1; bus.MemRData = 32'h55555555;
        tick();
        bus.MemReady = 1'b0;
        check("s_memwrite_off", 64'(bus.MemWrite), 64'd0);
        check("s_done", 64'(DatenGespeichert), 64'd1);
        check("s_befehl_kept", 64'(Befehl), 64'h8C220004);
        check("s_daten_kept", 64'(GeladeneDaten), 64'hDEADBEEF);
        StoreDatenSignal = 1'b0;
        tick();
        check("s_done_drop", 64'(DatenGespeichert), 64'd0);

        // priority: store beats fetch raised on the same edge
        PC = 32'h40; DatenAdresse = 32'h500; SchreibDaten = 32'hA5A5A5A5;
        bus.MemReady = 1'b1; bus.MemRData = 32'hCAFEF00D;
        LoadBefehlSignal = 1'b1; StoreDatenSignal = 1'b1;
        tick();
        check("p_memwrite", 64'(bus.MemWrite), 64'd1);
        check("p_memread", 64'(bus.MemRead), 64'd0);
        check("p_addr", 64'(bus.MemAddr), 64'h500);
        tick();
        check("p_store_done", 64'(DatenGespeichert), 64'd1);
        check("p_fetch_not_done", 64'(BefehlGeladen), 64'd0);
        StoreDatenSignal = 1'b0;
        tick();
        check("p_store_drop", 64'(DatenGespeichert), 64'd0);
        check("p_idle_gap", 64'(bus.MemRead), 64'd0);
        tick();
        check("p_fetch_read", 64'(bus.MemRead), 64'd1);
        check("p_fetch_addr", 64'(bus.MemAddr), 64'h40);
        tick();
        check("p_fetch_done", 64'(BefehlGeladen), 64'd1);
        check("p_befehl", 64'(Befehl), 64'hCAFEF00D);
        LoadBefehlSignal = 1'b0;
        tick();

        // timeout on a fetch
        bus.MemReady = 1'b0; PC = 32'h80; LoadBefehlSignal = 1'b1;
        tick();
        highCycles = 0;
        for (int i = 0; i < 40 && bus.MemRead; i++) begin
            highCycles++;
            tick();
        end
        check("t_strobe_len", 64'(highCycles), 64'd15);
        check("t_fehler", 64'(BusFehler), 64'd1);
        check("t_befehl", 64'(Befehl), 64'd0);
        check("t_done", 64'(BefehlGeladen), 64'd1);
        LoadBefehlSignal = 1'b0;
        tick();
        check("t_done_drop", 64'(BefehlGeladen), 64'd0);
        repeat (3) tick();
        check("t_fehler_sticky", 64'(BusFehler), 64'd1);

        // async reset in the middle of a load
        DatenAdresse = 32'h600; LoadDatenSignal = 1'b1;
        tick();
        check("r_memread_before", 64'(bus.MemRead), 64'd1);
        #2 Reset = 1'b1;
        #1;
        check("r_memread", 64'(bus.MemRead), 64'd0);
        check("r_addr", 64'(bus.MemAddr), 64'd0);
        check("r_fehler", 64'(BusFehler), 64'd0);
        check("r_daten", 64'(GeladeneDaten), 64'd0);
        check("r_done", 64'({BefehlGeladen, DatenGeladen, DatenGespeichert}), 64'd0);
        LoadDatenSignal = 1'b0;
        #1 Reset = 1'b0;
        PC = 32'h20; bus.MemReady = 1'b1; bus.MemRData = 32'h0BADF00D; LoadBefehlSignal = 1'b1;
        tick();
        check("r_fetch_read", 64'(bus.MemRead), 64'd1);
        check("r_fetch_addr", 64'(bus.MemAddr), 64'h20);
        tick();
        check("r_fetch_done", 64'(BefehlGeladen), 64'd1);
        check("r_fetch_befehl", 64'(Befehl), 64'h0BADF00D);
        check("r_fetch_fehler", 64'(BusFehler), 64'd0);
        LoadBefehlSignal = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
